// File: rtl/friscv_cache_stream_prefetcher.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : friscv_cache_stream_prefetcher
// Brief    : Cache miss handler issuing a demand fetch followed by a short
//            sequential prefetch stream on the memory controller AR channel.
// Revision : 1.0
//------------------------------------------------------------------------------
module friscv_cache_stream_prefetcher #(
  parameter NAME            = "stream_prefetcher",
  parameter ILEN            = 32,
  parameter XLEN            = 32,
  parameter AXI_ADDR_W      = 32,
  parameter AXI_ID_W        = 8,
  parameter AXI_DATA_W      = 128,
  parameter CACHE_BLOCK_W   = 128,
  parameter PREFETCH_DEPTH  = 2,
  parameter MAX_OUTSTANDING = 4,
  parameter PREFETCH_ID     = 'hF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  output logic                  memctrl_arvalid,
  input  logic                  memctrl_arready,
  output logic [AXI_ADDR_W-1:0] memctrl_araddr,
  output logic [2:0]            memctrl_arprot,
  output logic [AXI_ID_W-1:0]   memctrl_arid,
  input  logic                  mem_cpl_wr,
  input  logic [AXI_ID_W-1:0]   mem_cpl_rid,
  input  logic [AXI_ADDR_W-1:0] cache_raddr,
  input  logic [AXI_ID_W-1:0]   cache_rid,
  input  logic [2:0]            cache_rprot,
  input  logic                  cache_miss,
  output logic                  block_fill,
  output logic                  busy
);

  localparam int                     C_BLK_BYTES = CACHE_BLOCK_W / 8;
  localparam int                     C_OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [AXI_ADDR_W-1:0]  C_BLK_INC   = AXI_ADDR_W'(C_BLK_BYTES);
  localparam logic [AXI_ADDR_W-1:0]  C_OFF_MASK  = AXI_ADDR_W'(C_BLK_BYTES - 1);
  localparam logic [AXI_ID_W-1:0]    C_PF_ID     = AXI_ID_W'(PREFETCH_ID);
  localparam logic [C_OUT_W-1:0]     C_MAX_OUT   = C_OUT_W'(MAX_OUTSTANDING);
  localparam logic [3:0]             C_DEPTH     = 4'(PREFETCH_DEPTH);

  generate
    if ((AXI_DATA_W != CACHE_BLOCK_W) || (ILEN < 1) || (XLEN < 1) ||
        (PREFETCH_DEPTH > 15) || (MAX_OUTSTANDING < 1)) begin : g_bad_cfg
      $error("friscv_cache_stream_prefetcher: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEMAND   = 2'd1,
    S_WAIT     = 2'd2,
    S_PREFETCH = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [AXI_ADDR_W-1:0] r_raddr, r_miss_addr;
  logic [AXI_ID_W-1:0]   r_rid, r_miss_id, r_dem_id, w_dem_id_nxt;
  logic [2:0]            r_rprot, r_miss_prot;
  logic                  r_miss_pend, w_miss_pend_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic [AXI_ADDR_W-1:0] r_araddr, w_araddr_nxt;
  logic [AXI_ID_W-1:0]   r_arid, w_arid_nxt;
  logic [2:0]            r_arprot, w_arprot_nxt;
  logic [AXI_ADDR_W-1:0] r_next_addr, w_next_addr_nxt;
  logic [3:0]            r_pf_cnt, w_pf_cnt_nxt;
  logic [C_OUT_W-1:0]    r_out, w_out_nxt;
  logic                  r_block_fill, w_block_fill_nxt;

  logic                  w_hs, w_miss_any, w_room;
  logic [AXI_ADDR_W-1:0] w_fetch_addr;
  logic [AXI_ID_W-1:0]   w_miss_id;
  logic [2:0]            w_miss_prot;

  // A miss flagged this cycle refers to the address captured last cycle;
  // otherwise an earlier miss is still waiting in the latch.
  assign w_hs         = r_arvalid & memctrl_arready;
  assign w_miss_any   = cache_miss | r_miss_pend;
  assign w_fetch_addr = (cache_miss ? r_raddr : r_miss_addr) & ~C_OFF_MASK;
  assign w_miss_id    = cache_miss ? r_rid   : r_miss_id;
  assign w_miss_prot  = cache_miss ? r_rprot : r_miss_prot;
  assign w_room       = (r_out < C_MAX_OUT);

  always_comb begin
    w_state_nxt      = r_state;
    w_arvalid_nxt    = r_arvalid;
    w_araddr_nxt     = r_araddr;
    w_arid_nxt       = r_arid;
    w_arprot_nxt     = r_arprot;
    w_dem_id_nxt     = r_dem_id;
    w_next_addr_nxt  = r_next_addr;
    w_pf_cnt_nxt     = r_pf_cnt;
    w_miss_pend_nxt  = w_miss_any;
    w_block_fill_nxt = 1'b0;
    w_out_nxt        = r_out;

    case (r_state)
      S_IDLE: begin
        if (w_miss_any) begin
          if (w_room) begin
            w_state_nxt     = S_DEMAND;
            w_arvalid_nxt   = 1'b1;
            w_araddr_nxt    = w_fetch_addr;
            w_arid_nxt      = w_miss_id;
            w_arprot_nxt    = w_miss_prot;
            w_dem_id_nxt    = w_miss_id;
            w_miss_pend_nxt = 1'b0;
            // Continuing or restarting a stream both land on the block after the demand.
            w_next_addr_nxt = w_fetch_addr + C_BLK_INC;
            w_pf_cnt_nxt    = C_DEPTH;
          end
        end else if ((r_pf_cnt != 4'd0) && w_room) begin
          w_state_nxt   = S_PREFETCH;
          w_arvalid_nxt = 1'b1;
          w_araddr_nxt  = r_next_addr;
          w_arid_nxt    = C_PF_ID;
        end
      end
      S_DEMAND: begin
        if (w_hs) begin
          w_arvalid_nxt = 1'b0;
          w_state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_cpl_wr && (mem_cpl_rid == r_dem_id)) begin
          w_block_fill_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end
      end
      default: begin
        if (w_hs) begin
          w_arvalid_nxt   = 1'b0;
          w_next_addr_nxt = r_next_addr + C_BLK_INC;
          w_pf_cnt_nxt    = w_miss_any ? 4'd0 : (r_pf_cnt - 4'd1);
          w_state_nxt     = S_IDLE;
        end
      end
    endcase

    if (w_hs && !mem_cpl_wr) begin
      w_out_nxt = r_out + C_OUT_W'(1);
    end else if (!w_hs && mem_cpl_wr && (r_out != '0)) begin
      w_out_nxt = r_out - C_OUT_W'(1);
    end

    if (srst) begin
      w_state_nxt      = S_IDLE;
      w_arvalid_nxt    = 1'b0;
      w_araddr_nxt     = '0;
      w_arid_nxt       = '0;
      w_arprot_nxt     = '0;
      w_dem_id_nxt     = '0;
      w_next_addr_nxt  = '0;
      w_pf_cnt_nxt     = '0;
      w_miss_pend_nxt  = 1'b0;
      w_block_fill_nxt = 1'b0;
      w_out_nxt        = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_raddr      <= '0;
      r_rid        <= '0;
      r_rprot      <= '0;
      r_miss_addr  <= '0;
      r_miss_id    <= '0;
      r_miss_prot  <= '0;
      r_miss_pend  <= 1'b0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arid       <= '0;
      r_arprot     <= '0;
      r_dem_id     <= '0;
      r_next_addr  <= '0;
      r_pf_cnt     <= '0;
      r_out        <= '0;
      r_block_fill <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_raddr      <= cache_raddr;
      r_rid        <= cache_rid;
      r_rprot      <= cache_rprot;
      if (cache_miss) begin
        r_miss_addr <= r_raddr;
        r_miss_id   <= r_rid;
        r_miss_prot <= r_rprot;
      end
      r_miss_pend  <= w_miss_pend_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_araddr     <= w_araddr_nxt;
      r_arid       <= w_arid_nxt;
      r_arprot     <= w_arprot_nxt;
      r_dem_id     <= w_dem_id_nxt;
      r_next_addr  <= w_next_addr_nxt;
      r_pf_cnt     <= w_pf_cnt_nxt;
      r_out        <= w_out_nxt;
      r_block_fill <= w_block_fill_nxt;
    end
  end

  assign memctrl_arvalid = r_arvalid;
  assign memctrl_araddr  = r_araddr;
  assign memctrl_arid    = r_arid;
  assign memctrl_arprot  = r_arprot;
  assign block_fill      = r_block_fill;
  assign busy            = (r_state == S_DEMAND) || (r_state == S_WAIT) ||
                           r_miss_pend || (r_out != '0);

endmodule
`default_nettype wire

// File: tb/tb_friscv_cache_stream_prefetcher.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_friscv_cache_stream_prefetcher
// Brief    : Self-checking bench: AR stream per miss compared against a
//            miss -> {demand, next DEPTH blocks} reference list.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_friscv_cache_stream_prefetcher;

  localparam int         DEPTH = 2;
  localparam int         MAXO  = 2;
  localparam logic [7:0] PF_ID = 8'hF;

  logic        aclk = 1'b0;
  logic        aresetn, srst;
  logic        memctrl_arvalid, memctrl_arready;
  logic [31:0] memctrl_araddr;
  logic [2:0]  memctrl_arprot;
  logic [7:0]  memctrl_arid;
  logic        mem_cpl_wr;
  logic [7:0]  mem_cpl_rid;
  logic [31:0] cache_raddr;
  logic [7:0]  cache_rid;
  logic [2:0]  cache_rprot;
  logic        cache_miss;
  logic        block_fill, busy;

  friscv_cache_stream_prefetcher #(
    .PREFETCH_DEPTH  (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .PREFETCH_ID     (PF_ID)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .srst            (srst),
    .memctrl_arvalid (memctrl_arvalid),
    .memctrl_arready (memctrl_arready),
    .memctrl_araddr  (memctrl_araddr),
    .memctrl_arprot  (memctrl_arprot),
    .memctrl_arid    (memctrl_arid),
    .mem_cpl_wr      (mem_cpl_wr),
    .mem_cpl_rid     (mem_cpl_rid),
    .cache_raddr     (cache_raddr),
    .cache_rid       (cache_rid),
    .cache_rprot     (cache_rprot),
    .cache_miss      (cache_miss),
    .block_fill      (block_fill),
    .busy            (busy)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // ar_mode: 0 random ready, 1 ready low, 2 ready high
  // cpl_mode: 0 none, 1 demand IDs only, 2 everything
  int ar_mode  = 2;
  int cpl_mode = 2;

  logic [31:0] log_addr[$];
  logic [7:0]  log_id[$];
  logic [2:0]  log_prot[$];
  logic [7:0]  pend_q[$];
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_id[$];
  int          exp_prot[$];

  int cyc = 0, last_dcpl = -10, fill_cnt = 0, fill_bad = 0, stab_err = 0;
  int mdl_out = 0, max_out = 0;
  logic        held = 1'b0;
  logic [31:0] h_addr;
  logic [7:0]  h_id;
  logic [2:0]  h_prot;

  // Observer: handshakes, hold-stability, outstanding count, block_fill timing.
  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      held    = 1'b0;
      mdl_out = 0;
    end else begin
      if (held && !(memctrl_arvalid && memctrl_araddr == h_addr &&
                    memctrl_arid == h_id && memctrl_arprot == h_prot))
        stab_err++;
      held   = memctrl_arvalid && !memctrl_arready;
      h_addr = memctrl_araddr;
      h_id   = memctrl_arid;
      h_prot = memctrl_arprot;
      if (memctrl_arvalid && memctrl_arready) begin
        log_addr.push_back(memctrl_araddr);
        log_id.push_back(memctrl_arid);
        log_prot.push_back(memctrl_arprot);
        pend_q.push_back(memctrl_arid);
        mdl_out++;
      end
      if (mem_cpl_wr && mdl_out > 0) mdl_out--;
      if (mdl_out > max_out) max_out = mdl_out;
      if (mem_cpl_wr && mem_cpl_rid != PF_ID) last_dcpl = cyc;
      if (block_fill) begin
        fill_cnt++;
        if (last_dcpl != cyc - 1) fill_bad++;
      end
    end
  end

  // Memory side: arready pattern and in-order-agnostic completions.
  initial begin
    mem_cpl_wr      = 1'b0;
    mem_cpl_rid     = '0;
    memctrl_arready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      mem_cpl_wr = 1'b0;
      case (ar_mode)
        0:       memctrl_arready = ($urandom_range(0, 2) != 0);
        1:       memctrl_arready = 1'b0;
        default: memctrl_arready = 1'b1;
      endcase
      if (cpl_mode != 0 && pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        int idx;
        idx = -1;
        for (int i = 0; i < pend_q.size(); i++) begin
          if (cpl_mode == 2 || pend_q[i] != PF_ID) begin
            idx = i;
            break;
          end
        end
        if (idx >= 0) begin
          mem_cpl_wr  = 1'b1;
          mem_cpl_rid = pend_q[idx];
          pend_q.delete(idx);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a serviced miss yields its aligned block, then DEPTH following blocks.
  function automatic void model_stream(input logic [31:0] a, input logic [7:0] id,
                                       input int prot);
    logic [31:0] base;
    base = a & ~32'hF;
    exp_addr.push_back(base);
    exp_id.push_back(id);
    exp_prot.push_back(prot);
    for (int k = 1; k <= DEPTH; k++) begin
      exp_addr.push_back(base + 32'(16 * k));
      exp_id.push_back(PF_ID);
      exp_prot.push_back(-1);
    end
  endfunction

  task automatic check_log(input string tag);
    chk({tag, "_ar_count"}, 64'(log_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(log_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("%s_id%0d", tag, i), 64'(log_id[i]), 64'(exp_id[i]));
      if (exp_prot[i] >= 0)
        chk($sformatf("%s_prot%0d", tag, i), 64'(log_prot[i]), 64'(exp_prot[i]));
    end
    log_addr.delete(); log_id.delete(); log_prot.delete();
    exp_addr.delete(); exp_id.delete(); exp_prot.delete();
  endtask

  task automatic send_miss(input logic [31:0] a, input logic [7:0] id, input logic [2:0] prot);
    @(negedge aclk);
    cache_raddr = a;
    cache_rid   = id;
    cache_rprot = prot;
    @(negedge aclk);
    cache_miss = 1'b1;
    @(negedge aclk);
    cache_miss  = 1'b0;
    cache_raddr = $urandom;
    cache_rid   = 8'($urandom_range(0, 14));
  endtask

  task automatic wait_quiet(input string tag);
    int q, n;
    q = 0;
    n = 0;
    while (q < 4 && n < 3000) begin
      @(negedge aclk);
      n++;
      if (!busy && !memctrl_arvalid) q++;
      else q = 0;
    end
    chk({tag, "_quiet_timeout"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic txn(input string tag, input logic [31:0] a, input logic [7:0] id,
                     input logic [2:0] prot);
    int f0;
    f0 = fill_cnt;
    model_stream(a, id, int'(prot));
    send_miss(a, id, prot);
    wait_quiet(tag);
    check_log(tag);
    chk({tag, "_fills"}, 64'(fill_cnt - f0), 64'd1);
  endtask

  initial begin
    int f0, n;
    aresetn     = 1'b0;
    srst        = 1'b0;
    cache_raddr = '0;
    cache_rid   = '0;
    cache_rprot = '0;
    cache_miss  = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_arvalid", 64'(memctrl_arvalid), 64'd0);
    chk("rst_araddr", 64'(memctrl_araddr), 64'd0);
    chk("rst_arid", 64'(memctrl_arid), 64'd0);
    chk("rst_arprot", 64'(memctrl_arprot), 64'd0);
    chk("rst_block_fill", 64'(block_fill), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Directed streams, then randomized ones, then address wrap.
    ar_mode = 0;
    cpl_mode = 2;
    txn("s2000", 32'h2000, 8'd3, 3'd2);
    txn("s2030", 32'h2030, 8'd9, 3'd0);
    for (int t = 0; t < 8; t++)
      txn($sformatf("rnd%0d", t), $urandom, 8'($urandom_range(0, 14)),
          3'($urandom_range(0, 7)));
    txn("wrap", 32'hFFFF_FFF4, 8'd1, 3'd5);

    // Outstanding limit: hold prefetch completions so a new demand must stall.
    ar_mode = 2;
    cpl_mode = 1;
    f0 = fill_cnt;
    model_stream(32'h3000, 8'd5, 1);
    send_miss(32'h3000, 8'd5, 3'd1);
    n = 0;
    while (!(log_addr.size() == 3 && fill_cnt == f0 + 1) && n < 500) begin
      @(negedge aclk);
      n++;
    end
    chk("lim_first_stream_timeout", 64'(n < 500), 64'd1);
    repeat (5) @(negedge aclk);
    chk("lim_busy_outstanding", 64'(busy), 64'd1);
    model_stream(32'h4000, 8'd6, 3);
    send_miss(32'h4000, 8'd6, 3'd3);
    repeat (20) @(negedge aclk);
    chk("lim_no_third_ar", 64'(log_addr.size()), 64'd3);
    chk("lim_arvalid_low", 64'(memctrl_arvalid), 64'd0);
    chk("lim_busy_stalled", 64'(busy), 64'd1);
    cpl_mode = 2;
    wait_quiet("lim");
    check_log("lim");
    chk("lim_max_outstanding", 64'(max_out), 64'(MAXO));
    chk("lim_fills", 64'(fill_cnt - f0), 64'd2);

    // Miss while a prefetch AR is held: that AR finishes, then the new stream.
    f0 = fill_cnt;
    exp_addr.push_back(32'h5000); exp_id.push_back(8'd2); exp_prot.push_back(1);
    exp_addr.push_back(32'h5010); exp_id.push_back(PF_ID); exp_prot.push_back(-1);
    model_stream(32'h6000, 8'd4, 6);
    send_miss(32'h5000, 8'd2, 3'd1);
    n = 0;
    while (!block_fill && n < 500) begin
      @(negedge aclk);
      n++;
    end
    ar_mode = 1;
    chk("pre_fill_timeout", 64'(n < 500), 64'd1);
    repeat (3) @(negedge aclk);
    chk("pre_held_valid", 64'(memctrl_arvalid), 64'd1);
    chk("pre_held_addr", 64'(memctrl_araddr), 64'h5010);
    chk("pre_held_id", 64'(memctrl_arid), 64'(PF_ID));
    send_miss(32'h6000, 8'd4, 3'd6);
    repeat (2) @(negedge aclk);
    chk("pre_still_addr", 64'(memctrl_araddr), 64'h5010);
    chk("pre_still_valid", 64'(memctrl_arvalid), 64'd1);
    ar_mode = 2;
    wait_quiet("pre");
    check_log("pre");
    chk("pre_fills", 64'(fill_cnt - f0), 64'd2);

    // Asynchronous reset while waiting for the demand completion.
    cpl_mode = 0;
    f0 = fill_cnt;
    send_miss(32'h7000, 8'd1, 3'd0);
    n = 0;
    while (log_addr.size() == 0 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    repeat (2) @(negedge aclk);
    chk("ares_busy_in_wait", 64'(busy), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("ares_arvalid", 64'(memctrl_arvalid), 64'd0);
    chk("ares_busy", 64'(busy), 64'd0);
    chk("ares_araddr", 64'(memctrl_araddr), 64'd0);
    chk("ares_block_fill", 64'(block_fill), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    cpl_mode = 2;
    n = 0;
    while (pend_q.size() != 0 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    repeat (3) @(negedge aclk);
    chk("ares_late_cpl_busy", 64'(busy), 64'd0);
    chk("ares_late_cpl_fill", 64'(fill_cnt - f0), 64'd0);
    log_addr.delete(); log_id.delete(); log_prot.delete();

    // Synchronous reset during the demand wait.
    cpl_mode = 0;
    send_miss(32'h9000, 8'd2, 3'd0);
    repeat (4) @(negedge aclk);
    srst = 1'b1;
    @(negedge aclk);
    srst = 1'b0;
    chk("srst_arvalid", 64'(memctrl_arvalid), 64'd0);
    chk("srst_busy", 64'(busy), 64'd0);
    cpl_mode = 2;
    n = 0;
    while (pend_q.size() != 0 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    repeat (3) @(negedge aclk);
    log_addr.delete(); log_id.delete(); log_prot.delete();

    ar_mode = 0;
    txn("post_rst", 32'h8008, 8'd7, 3'd3);

    chk("ar_stable_while_held", 64'(stab_err), 64'd0);
    chk("fill_one_cycle_after_cpl", 64'(fill_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
